// File: rtl/debounce_multi_if.sv
// Bundle of the per-channel button signals exchanged between the raw
// input side (master) and the debouncer (slave).
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] src;
  logic [CHANNELS-1:0] dst;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] hold;

  modport master (
    output src,
    input  dst,
    input  rise,
    input  fall,
    input  hold
  );

  modport slave (
    input  src,
    output dst,
    output rise,
    output fall,
    output hold
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer. Each channel has a 2-flop synchroniser, a
// debounce counter that toggles the clean level after THRESH consecutive
// disagreeing samples, one-cycle rise/fall strobes and a long-press flag.
module debounce_multi #(
  parameter int   CHANNELS     = 4,
  parameter int   CLK_FREQ_KHZ = 100_000,
  parameter int   DEBOUNCE_MS  = 1,
  parameter int   HOLD_MS      = 500,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  debounce_multi_if.slave  bus
);

  localparam int THRESH   = CLK_FREQ_KHZ * DEBOUNCE_MS;
  localparam int HOLD_CYC = CLK_FREQ_KHZ * HOLD_MS;
  localparam int CNT_W    = $clog2(THRESH + 1);
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [CHANNELS-1:0] sync0;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] hold_hit;
  logic [CNT_W-1:0]    count      [CHANNELS];
  logic [HOLD_W-1:0]   hold_count [CHANNELS];

  // Two-stage synchroniser bringing the asynchronous inputs into clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= {CHANNELS{RESET_VAL}};
      sync1 <= {CHANNELS{RESET_VAL}};
    end else begin
      sync0 <= bus.src;
      sync1 <= sync0;
    end
  end

  // Debounce counter per channel; flips the clean level and fires a strobe
  // once the synchronised input has disagreed for THRESH cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= {CHANNELS{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync1[i] == level[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          count[i]  <= '0;
          level[i]  <= ~level[i];
          rise_q[i] <= ~level[i];
          fall_q[i] <= level[i];
        end else begin
          count[i] <= count[i] + CNT_ONE;
        end
      end
    end
  end

  // Long-press counter: runs while the clean level is high, saturates so
  // it can never wrap, and is cleared as soon as the level is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hold_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!level[i]) begin
          hold_count[i] <= '0;
        end else if (hold_count[i] != HOLD_MAX) begin
          hold_count[i] <= hold_count[i] + HOLD_ONE;
        end
      end
    end
  end

  // Saturation detect; qualified with the level below so hold drops in the
  // same cycle the level falls.
  always_comb begin
    hold_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_hit[i] = (hold_count[i] == HOLD_MAX);
    end
  end

  assign bus.dst  = level;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.hold = hold_hit & level;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus pushes expected strobe and
// hold events (kind, channel, edge number); a monitor pops them as the DUT
// produces them and compares the edge at which they appear.
module tb_debounce_multi;

  localparam int CH     = 2;
  localparam int THRESH = 10;
  localparam int HOLD   = 50;

  localparam int EV_RISE     = 0;
  localparam int EV_FALL     = 1;
  localparam int EV_HOLD_ON  = 2;
  localparam int EV_HOLD_OFF = 3;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];
  logic [CH-1:0] prev_hold;

  debounce_multi_if #(.CHANNELS(CH)) bus ();

  debounce_multi #(
    .CHANNELS    (CH),
    .CLK_FREQ_KHZ(10),
    .DEBOUNCE_MS (1),
    .HOLD_MS     (5),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expectEvent(input int kind, input int ch, input int at);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = at;
    exp_q.push_back(e);
  endfunction

  function automatic string kindName(input int kind);
    case (kind)
      EV_RISE:    return "rise";
      EV_FALL:    return "fall";
      EV_HOLD_ON: return "hold_on";
      default:    return "hold_off";
    endcase
  endfunction

  // Pop the oldest pending event of this kind/channel and compare its edge.
  function automatic void matchEvent(input int kind, input int ch);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("[TB] FAIL unexpected_%s ch%0d: seen at edge %0d, none expected",
               kindName(kind), ch, cyc);
    end else begin
      if (exp_q[idx].cyc != cyc) begin
        errors++;
        $display("[TB] FAIL %s_edge ch%0d: got edge %0d, expected edge %0d",
                 kindName(kind), ch, cyc, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endfunction

  // Monitor: any strobe or hold transition is an output event to score.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (bus.rise[c] && bus.fall[c]) begin
          checks++;
          errors++;
          $display("[TB] FAIL rise_fall_both ch%0d: got both at edge %0d, expected at most one", c, cyc);
        end
        if (bus.rise[c]) begin
          matchEvent(EV_RISE, c);
          checks++;
          if (bus.dst[c] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dst_on_rise ch%0d: got %b, expected 1", c, bus.dst[c]);
          end
        end
        if (bus.fall[c]) begin
          matchEvent(EV_FALL, c);
          checks++;
          if (bus.dst[c] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dst_on_fall ch%0d: got %b, expected 0", c, bus.dst[c]);
          end
        end
        if (bus.hold[c] && !prev_hold[c]) matchEvent(EV_HOLD_ON, c);
        if (!bus.hold[c] && prev_hold[c]) matchEvent(EV_HOLD_OFF, c);
      end
    end
    prev_hold = bus.hold;
  end

  // Drive src at a negedge; returns the number of the next rising edge.
  task automatic applyStimulus(input logic [CH-1:0] v, output int next_edge);
    @(negedge clk);
    bus.src   = v;
    next_edge = cyc + 1;
  endtask

  // Direct comparison of all output vectors at the current moment.
  task automatic checkOutput(input string name, input logic [CH-1:0] e_dst,
                             input logic [CH-1:0] e_rise, input logic [CH-1:0] e_fall,
                             input logic [CH-1:0] e_hold);
    logic [4*CH-1:0] got, want;
    got  = {bus.dst, bus.rise, bus.fall, bus.hold};
    want = {e_dst, e_rise, e_fall, e_hold};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got dst/rise/fall/hold=%b, expected %b", name, got, want);
    end
  endtask

  // Wait (bounded) for every pending expected event to be observed.
  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    int e2;
    checks    = 0;
    errors    = 0;
    prev_hold = '0;
    rst       = 1'b1;
    bus.src   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);

    // Single rise, held 80 cycles into long press, then released.
    $display("[TB] phase: rise, hold and release on ch0");
    applyStimulus(2'b01, e);
    expectEvent(EV_RISE, 0, e + THRESH + 1);
    expectEvent(EV_HOLD_ON, 0, e + THRESH + 1 + HOLD);
    repeat (20) @(negedge clk);
    checkOutput("ch1_idle", 2'b01, 2'b00, 2'b00, 2'b00);
    repeat (59) @(negedge clk);
    applyStimulus(2'b00, e2);
    expectEvent(EV_FALL, 0, e2 + THRESH + 1);
    expectEvent(EV_HOLD_OFF, 0, e2 + THRESH + 1);
    waitDrain("hold_release", 40);

    // Pulses one cycle shorter than the threshold must never get through.
    $display("[TB] phase: short pulses on ch0");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b01, e);
      repeat (8) @(negedge clk);
      applyStimulus(2'b00, e);
      repeat (5) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    checkOutput("short_pulses", 2'b00, 2'b00, 2'b00, 2'b00);

    // One-cycle low glitch after six high samples restarts the count.
    $display("[TB] phase: glitch on ch0");
    applyStimulus(2'b01, e);
    repeat (5) @(negedge clk);
    applyStimulus(2'b00, e2);
    applyStimulus(2'b01, e2);
    expectEvent(EV_RISE, 0, e + 18);
    waitDrain("glitch_rise", 40);
    applyStimulus(2'b00, e);
    expectEvent(EV_FALL, 0, e + THRESH + 1);
    waitDrain("glitch_fall", 40);

    // Both channels switched on the same edge.
    $display("[TB] phase: simultaneous channels");
    applyStimulus(2'b11, e);
    expectEvent(EV_RISE, 0, e + THRESH + 1);
    expectEvent(EV_RISE, 1, e + THRESH + 1);
    waitDrain("dual_rise", 40);
    checkOutput("dual_level", 2'b11, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b00, e);
    expectEvent(EV_FALL, 0, e + THRESH + 1);
    expectEvent(EV_FALL, 1, e + THRESH + 1);
    waitDrain("dual_fall", 40);

    // Asynchronous reset in the middle of a count (count == 7).
    $display("[TB] phase: async reset mid-count");
    applyStimulus(2'b01, e);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    checkOutput("in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    e   = cyc + 1;
    expectEvent(EV_RISE, 0, e + THRESH + 1);
    @(negedge clk);
    checkOutput("reset_release", 2'b00, 2'b00, 2'b00, 2'b00);
    waitDrain("post_reset_rise", 40);
    applyStimulus(2'b00, e);
    expectEvent(EV_FALL, 0, e + THRESH + 1);
    waitDrain("post_reset_fall", 40);
    repeat (5) @(negedge clk);
    checkOutput("final_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
